// File: rtl/jtframe_db15_pkg.sv
// DB15 adapter shared types: FSM states, word widths, frame bit mapping.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package jtframe_db15_pkg;

  localparam int JOYW   = 12;
  localparam int FRAMEW = 2 * JOYW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit k of the result is the k-th bit presented on the wire (k=0 first).
  // Player 1 goes out first, then player 2, both inverted to active-low.
  function automatic logic [FRAMEW-1:0] frame_word(
    input logic [JOYW-1:0] joy1,
    input logic [JOYW-1:0] joy2
  );
    frame_word = ~{joy2, joy1};
  endfunction

endpackage

// File: rtl/jtframe_sync.sv
// Multi-flop synchronizer for asynchronous single-bit strobes, W bits wide.
// Latency: DEPTH clk_sys cycles from pin to dout.
// Backpressure: none; samples every cycle.
module jtframe_sync #(
  parameter int             DEPTH   = 2,
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] chain;

  // Shift the raw pins through DEPTH flops; reset to the idle pin levels
  // so no false edge is seen right after reset release.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {DEPTH{RST_VAL}};
    end else begin
      chain <= {chain[DEPTH-2:0], din};
    end
  end

  assign dout = chain[DEPTH-1];

endmodule

// File: rtl/jtframe_db15_tx.sv
// DB15 joystick adapter emulation: parallel button words out as an active-low serial frame.
// Latency: JOY_DATA moves SYNC_STAGES+1 clk_sys cycles after a JOY_CLK rise / JOY_LOAD fall at the pin.
// Backpressure: none; the reader paces the frame with JOY_LOAD/JOY_CLK.
module jtframe_db15_tx
  import jtframe_db15_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 960000
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic [JOYW-1:0] joystick1,
  input  logic [JOYW-1:0] joystick2,
  input  logic            JOY_LOAD,
  input  logic            JOY_CLK,
  output logic            JOY_DATA,
  output logic            frame_done,
  output logic            link_ok
);

  localparam logic [19:0] WD_MAX   = 20'(TIMEOUT);
  localparam logic [4:0]  LAST_IDX = 5'(FRAMEW - 1);

  logic              ld_s, ck_s;
  logic              ld_q, ck_q;
  logic              ld_fall, ld_rise, ck_rise;
  state_t            state;
  logic [FRAMEW-1:0] sreg;
  logic [4:0]        cnt;
  logic [19:0]       wd_cnt;
  logic              load_seen;

  jtframe_sync #(
    .DEPTH   (SYNC_STAGES),
    .W       (2),
    .RST_VAL (2'b10)
  ) u_sync (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .din     ({JOY_LOAD, JOY_CLK}),
    .dout    ({ld_s, ck_s})
  );

  // Previous synced levels, for edge detection.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ld_q <= 1'b1;
      ck_q <= 1'b0;
    end else begin
      ld_q <= ld_s;
      ck_q <= ck_s;
    end
  end

  assign ld_fall = ld_q & ~ld_s;
  assign ld_rise = ~ld_q & ld_s;
  assign ck_rise = ~ck_q & ck_s;

  // Frame FSM: load dominates everything; otherwise shift on JOY_CLK rises,
  // feeding 1s (released) in behind the frame.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '1;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!ld_s) begin
        state <= LOAD;
        sreg  <= frame_word(joystick1, joystick2);
        cnt   <= '0;
      end else begin
        case (state)
          LOAD: begin
            // Register freezes from here until the next load.
            if (ld_rise) state <= SHIFT;
          end
          SHIFT: begin
            if (ck_rise) begin
              sreg <= {1'b1, sreg[FRAMEW-1:1]};
              cnt  <= cnt + 5'd1;
              if (cnt == LAST_IDX - 5'd1) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end
            end
          end
          default: begin
            // IDLE and DONE: keep shifting out released bits, count held.
            if (ck_rise) sreg <= {1'b1, sreg[FRAMEW-1:1]};
          end
        endcase
      end
    end
  end

  assign JOY_DATA = sreg[0];

  // Link watchdog: cleared by each load strobe, saturates at WD_MAX.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= WD_MAX;
      load_seen <= 1'b0;
    end else if (ld_fall) begin
      wd_cnt    <= '0;
      load_seen <= 1'b1;
    end else if (wd_cnt < WD_MAX) begin
      wd_cnt <= wd_cnt + 20'd1;
    end
  end

  assign link_ok = load_seen & (wd_cnt < WD_MAX);

endmodule

// File: tb/tb_jtframe_db15_tx.sv
module tb_jtframe_db15_tx;
  import jtframe_db15_pkg::*;

  localparam int SYNC = 2;
  localparam int TO   = 100;
  localparam int PH   = 5;   // reader phase length in clk_sys cycles

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [11:0] joystick1 = '0;
  logic [11:0] joystick2 = '0;
  logic        JOY_LOAD = 1'b1;
  logic        JOY_CLK  = 1'b0;
  logic        JOY_DATA, frame_done, link_ok;

  int n_chk  = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  logic fd_dat = 1'b1;
  logic exp_q[$];

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    logic [11:0] j1_late;
    logic [11:0] j2_late;
    int          nclk;
  } vec_t;

  vec_t vt[6];

  jtframe_db15_tx #(.SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_CLK    (JOY_CLK),
    .JOY_DATA   (JOY_DATA),
    .frame_done (frame_done),
    .link_ok    (link_ok)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_dat = JOY_DATA;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "bench time limit");
  end

  function automatic logic exp_bit(input logic [11:0] a, input logic [11:0] b, input int k);
    logic [23:0] w;
    if (k >= 24) return 1'b1;
    w = ~{b, a};
    w = w >> k;
    return w[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic sample(input int vi, input int k);
    logic e;
    if (exp_q.size() == 0) begin
      chk($sformatf("v%0d_k%0d_queue_empty", vi, k), 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("v%0d_k%0d", vi, k), {31'd0, JOY_DATA}, {31'd0, e});
    end
  endtask

  // Reader: load pulse, read bit 0, then nclk clocks each followed by a read.
  task automatic run_frame(input vec_t v, input int vi);
    int base;
    int exp_fd;
    base = fd_cnt;
    exp_fd = (v.nclk >= 23) ? 1 : 0;
    for (int k = 0; k <= v.nclk; k++) exp_q.push_back(exp_bit(v.j1, v.j2, k));
    joystick1 = v.j1;
    joystick2 = v.j2;
    JOY_LOAD = 1'b0;
    cyc(PH);
    JOY_LOAD = 1'b1;
    cyc(3);
    joystick1 = v.j1_late;
    joystick2 = v.j2_late;
    cyc(PH - 3);
    sample(vi, 0);
    for (int c = 1; c <= v.nclk; c++) begin
      JOY_CLK = 1'b1;
      cyc(PH);
      sample(vi, c);
      JOY_CLK = 1'b0;
      cyc(PH);
    end
    chk($sformatf("v%0d_frame_done_count", vi), 32'(fd_cnt - base), 32'(exp_fd));
    if (exp_fd == 1)
      chk($sformatf("v%0d_frame_done_bit23", vi), {31'd0, fd_dat},
          {31'd0, exp_bit(v.j1, v.j2, 23)});
  endtask

  initial begin
    int   first_low;
    vec_t v;

    vt[0] = '{12'h001, 12'h800, 12'h001, 12'h800, 24};
    vt[1] = '{12'h001, 12'h800, 12'hFFF, 12'hFFF, 24};
    vt[2] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 24};
    vt[3] = '{12'h5A5, 12'h3C3, 12'h5A5, 12'h3C3, 10};
    vt[4] = '{12'hA5C, 12'h1E7, 12'hA5C, 12'h1E7, 24};
    vt[5] = '{12'h0F0, 12'hF0F, 12'h0F0, 12'hF0F, 30};

    // Reset state
    cyc(3);
    chk("rst_joy_data", {31'd0, JOY_DATA}, 32'd1);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_link_ok", {31'd0, link_ok}, 32'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_cnt", 32'(dut.cnt), 32'd0);

    // Pin-to-output latency on a load fall: data moves on the 3rd edge
    joystick1 = 12'h001;
    joystick2 = 12'h800;
    JOY_LOAD = 1'b0;
    cyc(1);
    chk("lat_edge1", {31'd0, JOY_DATA}, 32'd1);
    cyc(1);
    chk("lat_edge2", {31'd0, JOY_DATA}, 32'd1);
    chk("link_edge2", {31'd0, link_ok}, 32'd0);
    cyc(1);
    chk("lat_edge3", {31'd0, JOY_DATA}, 32'd0);
    chk("link_edge3", {31'd0, link_ok}, 32'd1);
    cyc(2);
    JOY_LOAD = 1'b1;
    cyc(PH);

    // Table-driven frames (v3 aborts mid-frame, v4 follows the abort)
    for (int i = 0; i < 6; i++) run_frame(vt[i], i);
    chk("overrun_cnt_hold", 32'(dut.cnt), 32'd23);
    chk("overrun_state", 32'(dut.state), 32'(DONE));

    // Clock edge while load held low is ignored
    joystick1 = 12'h002;
    joystick2 = 12'h000;
    JOY_LOAD = 1'b0;
    cyc(PH);
    JOY_CLK = 1'b1;
    cyc(PH);
    chk("load_dom_data", {31'd0, JOY_DATA}, 32'd1);
    chk("load_dom_cnt", 32'(dut.cnt), 32'd0);
    JOY_CLK = 1'b0;
    cyc(PH);
    JOY_LOAD = 1'b1;
    cyc(PH);
    JOY_CLK = 1'b1;
    cyc(PH);
    chk("load_dom_bit1", {31'd0, JOY_DATA}, 32'd0);
    JOY_CLK = 1'b0;
    cyc(PH);

    // Watchdog: expire, then restore and time the next expiry
    cyc(150);
    chk("wd_expired", {31'd0, link_ok}, 32'd0);
    JOY_LOAD = 1'b0;
    first_low = -1;
    for (int n = 1; n <= 300; n++) begin
      cyc(1);
      if (n == 2) chk("wd_restore_edge2", {31'd0, link_ok}, 32'd0);
      if (n == 3) chk("wd_restore_edge3", {31'd0, link_ok}, 32'd1);
      if (n == 5) JOY_LOAD = 1'b1;
      if (n > 3 && !link_ok) begin
        first_low = n;
        break;
      end
    end
    chk("wd_fall_edge", 32'(first_low), 32'(SYNC + 1 + TO));

    // Asynchronous reset in the middle of a frame
    v = '{12'h020, 12'h000, 12'h020, 12'h000, 5};
    run_frame(v, 6);
    chk("pre_rst_link_ok", {31'd0, link_ok}, 32'd1);
    chk("pre_rst_joy_data", {31'd0, JOY_DATA}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_joy_data", {31'd0, JOY_DATA}, 32'd1);
    chk("mid_rst_link_ok", {31'd0, link_ok}, 32'd0);
    chk("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    v = '{12'h0F0, 12'h00F, 12'h0F0, 12'h00F, 24};
    run_frame(v, 7);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
